// File: rtl/axi_tagctrl_tag_req_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axi_tagctrl_tag_req_gen : AXI burst -> per-tag-word request stream, Rev 1.0 |
// +-----------------------------------------------------------------------------+
module axi_tagctrl_tag_req_gen #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned CapSize      = 128,
  parameter int unsigned TagLineWidth = 64,
  parameter int unsigned NumRegions   = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumRegions-1:0][AxiAddrWidth-1:0]  region_base_i,
  input  logic [NumRegions-1:0][AxiAddrWidth-1:0]  region_len_i,
  input  logic [NumRegions-1:0][AxiAddrWidth-1:0]  region_tag_base_i,
  input  logic                                     ax_valid_i,
  output logic                                     ax_ready_o,
  input  logic [AxiAddrWidth-1:0]                  ax_addr_i,
  input  logic [7:0]                               ax_len_i,
  input  logic [2:0]                               ax_size_i,
  input  logic [1:0]                               ax_burst_i,
  input  logic [AxiIdWidth-1:0]                    ax_id_i,
  output logic                                     req_valid_o,
  input  logic                                     req_ready_i,
  output logic [AxiAddrWidth-1:0]                  req_addr_o,
  output logic [$clog2(TagLineWidth)-1:0]          req_bit_lo_o,
  output logic [$clog2(TagLineWidth)-1:0]          req_bit_hi_o,
  output logic [AxiIdWidth-1:0]                    req_id_o,
  output logic                                     req_last_o,
  output logic                                     req_hit_o,
  output logic                                     req_err_o,
  output logic                                     busy_o
);

  localparam int unsigned ADDR_W       = AxiAddrWidth;
  localparam int unsigned BIT_W        = $clog2(TagLineWidth);
  localparam int unsigned CAP_SHIFT    = $clog2(CapSize / 8);
  localparam int unsigned STRIDE_SHIFT = $clog2(TagLineWidth / 8);
  localparam logic [BIT_W-1:0]  BIT_MAX = BIT_W'(TagLineWidth - 1);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(TagLineWidth / 8);
  localparam logic [ADDR_W:0]   ONE_X   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GEN    = 2'd1,
    SINGLE = 2'd2
  } state_t;

  state_t state;

  // Burst span is computed one bit wider so that a wrap past the top of the
  // address space shows up as bit ADDR_W and can be excluded from every region.
  logic [ADDR_W:0] total;
  logic [ADDR_W:0] span_start;
  logic [ADDR_W:0] span_end;

  always_comb begin
    total      = ({{(ADDR_W-7){1'b0}}, ax_len_i} + ONE_X) << ax_size_i;
    span_start = {1'b0, ax_addr_i};
    span_end   = span_start + total - ONE_X;
    unique case (ax_burst_i)
      2'b01: ;
      2'b10: begin
        span_start = {1'b0, ax_addr_i} & ~(total - ONE_X);
        span_end   = span_start + total - ONE_X;
      end
      default: span_end = span_start + (ONE_X << ax_size_i) - ONE_X;
    endcase
  end

  logic [NumRegions-1:0] full;
  logic [NumRegions-1:0] touch;

  generate
    for (genvar r = 0; r < NumRegions; r++) begin : g_region
      logic [ADDR_W:0] base_x;
      logic [ADDR_W:0] limit_x;
      logic            enabled;
      assign base_x   = {1'b0, region_base_i[r]};
      assign limit_x  = base_x + {1'b0, region_len_i[r]};
      assign enabled  = (region_len_i[r] != '0) && !span_end[ADDR_W];
      assign full[r]  = enabled && (span_start >= base_x) && (span_end < limit_x);
      assign touch[r] = enabled && (span_start < limit_x) && (span_end >= base_x);
    end
  endgenerate

  logic              any_full;
  logic [ADDR_W-1:0] sel_base;
  logic [ADDR_W-1:0] sel_tag_base;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    any_full     = 1'b0;
    sel_base     = '0;
    sel_tag_base = '0;
    for (int r = int'(NumRegions) - 1; r >= 0; r--) begin
      if (full[r]) begin
        any_full     = 1'b1;
        sel_base     = region_base_i[r];
        sel_tag_base = region_tag_base_i[r];
      end
    end
  end

  logic [ADDR_W-1:0] cap_start;
  logic [ADDR_W-1:0] cap_end;
  logic [ADDR_W-1:0] word_first;
  logic [ADDR_W-1:0] word_last;

  assign cap_start  = (span_start[ADDR_W-1:0] - sel_base) >> CAP_SHIFT;
  assign cap_end    = (span_end[ADDR_W-1:0] - sel_base) >> CAP_SHIFT;
  assign word_first = cap_start >> BIT_W;
  assign word_last  = cap_end >> BIT_W;

  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] word_end;
  logic [BIT_W-1:0]  end_bit;
  logic [ADDR_W-1:0] next_idx;

  assign next_idx = word_idx + ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ax_ready_o   <= 1'b1;
      busy_o       <= 1'b0;
      req_valid_o  <= 1'b0;
      req_addr_o   <= '0;
      req_bit_lo_o <= '0;
      req_bit_hi_o <= '0;
      req_id_o     <= '0;
      req_last_o   <= 1'b0;
      req_hit_o    <= 1'b0;
      req_err_o    <= 1'b0;
      word_idx     <= '0;
      word_end     <= '0;
      end_bit      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ax_valid_i) begin
            ax_ready_o  <= 1'b0;
            busy_o      <= 1'b1;
            req_valid_o <= 1'b1;
            req_id_o    <= ax_id_i;
            if (any_full) begin
              state        <= GEN;
              word_idx     <= word_first;
              word_end     <= word_last;
              end_bit      <= cap_end[BIT_W-1:0];
              req_addr_o   <= sel_tag_base + (word_first << STRIDE_SHIFT);
              req_bit_lo_o <= cap_start[BIT_W-1:0];
              req_bit_hi_o <= (word_first == word_last) ? cap_end[BIT_W-1:0] : BIT_MAX;
              req_last_o   <= (word_first == word_last);
              req_hit_o    <= 1'b1;
              req_err_o    <= 1'b0;
            end else begin
              state        <= SINGLE;
              req_addr_o   <= '0;
              req_bit_lo_o <= '0;
              req_bit_hi_o <= '0;
              req_last_o   <= 1'b1;
              req_hit_o    <= 1'b0;
              req_err_o    <= |touch;
            end
          end
        end
        GEN, SINGLE: begin
          if (req_ready_i) begin
            if (req_last_o) begin
              state        <= IDLE;
              ax_ready_o   <= 1'b1;
              busy_o       <= 1'b0;
              req_valid_o  <= 1'b0;
              req_addr_o   <= '0;
              req_bit_lo_o <= '0;
              req_bit_hi_o <= '0;
              req_id_o     <= '0;
              req_last_o   <= 1'b0;
              req_hit_o    <= 1'b0;
              req_err_o    <= 1'b0;
            end else begin
              // Only GEN reaches here; SINGLE always carries last.
              word_idx     <= next_idx;
              req_addr_o   <= req_addr_o + STRIDE;
              req_bit_lo_o <= '0;
              req_bit_hi_o <= (next_idx == word_end) ? end_bit : BIT_MAX;
              req_last_o   <= (next_idx == word_end);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_tagctrl_tag_req_gen.sv
`default_nettype none
// Bench for axi_tagctrl_tag_req_gen: directed scenarios plus random bursts
// scored against a capability-by-capability reference model.
module tb_axi_tagctrl_tag_req_gen;

  localparam int AW  = 64;
  localparam int IW  = 4;
  localparam int CAP = 128;
  localparam int TLW = 64;
  localparam int NR  = 2;
  localparam int BW  = $clog2(TLW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0][AW-1:0] region_base     = '0;
  logic [NR-1:0][AW-1:0] region_len      = '0;
  logic [NR-1:0][AW-1:0] region_tag_base = '0;
  logic          ax_valid = 1'b0;
  logic          ax_ready;
  logic [AW-1:0] ax_addr  = '0;
  logic [7:0]    ax_len   = '0;
  logic [2:0]    ax_size  = '0;
  logic [1:0]    ax_burst = '0;
  logic [IW-1:0] ax_id    = '0;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_bit_lo;
  logic [BW-1:0] req_bit_hi;
  logic [IW-1:0] req_id;
  logic          req_last;
  logic          req_hit;
  logic          req_err;
  logic          busy;

  axi_tagctrl_tag_req_gen #(
    .AxiAddrWidth(AW), .AxiIdWidth(IW), .CapSize(CAP), .TagLineWidth(TLW), .NumRegions(NR)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .region_base_i(region_base), .region_len_i(region_len), .region_tag_base_i(region_tag_base),
    .ax_valid_i(ax_valid), .ax_ready_o(ax_ready), .ax_addr_i(ax_addr), .ax_len_i(ax_len),
    .ax_size_i(ax_size), .ax_burst_i(ax_burst), .ax_id_i(ax_id),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_addr_o(req_addr),
    .req_bit_lo_o(req_bit_lo), .req_bit_hi_o(req_bit_hi), .req_id_o(req_id),
    .req_last_o(req_last), .req_hit_o(req_hit), .req_err_o(req_err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [63:0] addr;
    int          lo;
    int          hi;
    bit          last;
    bit          hit;
    bit          err;
  } exp_t;

  exp_t expq[$];

  // Reference: walk every capability the burst covers and group by tag word.
  task automatic model(input logic [63:0] a, input logic [7:0] l, input logic [2:0] sz,
                       input logic [1:0] b);
    logic [64:0] total, s, e, lim, bx;
    int hitr;
    bit ov, have;
    longint unsigned cs, ce, w, cw;
    exp_t cur;
    expq.delete();
    hitr  = -1;
    ov    = 0;
    have  = 0;
    cw    = 0;
    cur   = '{addr: 64'd0, lo: 0, hi: 0, last: 1'b0, hit: 1'b0, err: 1'b0};
    total = (65'(l) + 65'd1) << sz;
    s = {1'b0, a};
    if (b == 2'b01)      e = s + total - 65'd1;
    else if (b == 2'b10) begin s = {1'b0, a} & ~(total - 65'd1); e = s + total - 65'd1; end
    else                 e = s + (65'd1 << sz) - 65'd1;
    if (!e[64]) begin
      for (int r = 0; r < NR; r++) begin
        bx  = {1'b0, region_base[r]};
        lim = bx + {1'b0, region_len[r]};
        if (region_len[r] != 0) begin
          if (hitr < 0 && s >= bx && e < lim) hitr = r;
          if (s < lim && e >= bx) ov = 1;
        end
      end
    end
    if (hitr >= 0) begin
      cs = (s[63:0] - region_base[hitr]) / (CAP / 8);
      ce = (e[63:0] - region_base[hitr]) / (CAP / 8);
      for (longint unsigned c = cs; c <= ce; c++) begin
        w = c / TLW;
        if (have && w != cw) begin expq.push_back(cur); have = 0; end
        if (!have) begin
          cur.addr = region_tag_base[hitr] + w * (TLW / 8);
          cur.lo = int'(c % TLW); cur.last = 0; cur.hit = 1; cur.err = 0;
          cw = w; have = 1;
        end
        cur.hi = int'(c % TLW);
      end
      cur.last = 1;
      expq.push_back(cur);
    end else begin
      cur = '{addr: 64'd0, lo: 0, hi: 0, last: 1'b1, hit: 1'b0, err: ov};
      expq.push_back(cur);
    end
  endtask

  task automatic check_beat(input exp_t ex, input logic [IW-1:0] id);
    check("req_addr", req_addr, ex.addr);
    check("req_bit_lo", 64'(req_bit_lo), 64'(ex.lo));
    check("req_bit_hi", 64'(req_bit_hi), 64'(ex.hi));
    check("req_last", 64'(req_last), 64'(ex.last));
    check("req_hit", 64'(req_hit), 64'(ex.hit));
    check("req_err", 64'(req_err), 64'(ex.err));
    check("req_id", 64'(req_id), 64'(id));
  endtask

  task automatic send_ax(input logic [63:0] a, input logic [7:0] l, input logic [2:0] sz,
                         input logic [1:0] b, input logic [IW-1:0] id, output bit ok);
    int cyc;
    cyc = 0;
    ax_addr = a; ax_len = l; ax_size = sz; ax_burst = b; ax_id = id; ax_valid = 1'b1;
    while (!ax_ready && cyc < 50) begin @(negedge clk); cyc++; end
    ok = ax_ready;
    if (!ok) check("ax_accept_timeout", 64'(ax_ready), 64'd1);
    @(negedge clk);
    ax_valid = 1'b0;
  endtask

  task automatic run_ax(input logic [63:0] a, input logic [7:0] l, input logic [2:0] sz,
                        input logic [1:0] b, input logic [IW-1:0] id, input int rdy_pct);
    logic [NR-1:0][AW-1:0] sv_base, sv_len, sv_tb;
    exp_t ex;
    bit ok;
    int cyc;
    model(a, l, sz, b);
    send_ax(a, l, sz, b, id, ok);
    if (!ok) return;
    check("first_valid", 64'(req_valid), 64'd1);
    check("ax_ready_busy", 64'(ax_ready), 64'd0);
    check("busy_set", 64'(busy), 64'd1);
    // Region ports must have no effect once the burst is accepted.
    sv_base = region_base; sv_len = region_len; sv_tb = region_tag_base;
    region_tag_base = ~region_tag_base;
    region_base[0] = region_base[0] + 64'h1000;
    region_len[NR-1] = '0;
    cyc = 0;
    while (expq.size() != 0 && cyc < 400) begin
      check("req_valid", 64'(req_valid), 64'd1);
      check_beat(expq[0], id);
      req_ready = ($urandom_range(0, 99) < rdy_pct);
      if (req_valid && req_ready) ex = expq.pop_front();
      @(negedge clk);
      cyc++;
    end
    req_ready = 1'b0;
    check("beats_outstanding", 64'(expq.size()), 64'd0);
    check("idle_valid", 64'(req_valid), 64'd0);
    check("idle_ax_ready", 64'(ax_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    region_base = sv_base; region_len = sv_len; region_tag_base = sv_tb;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t ex;
    bit ok;
    logic [63:0] a;
    repeat (2) @(negedge clk);
    check("rst_ax_ready", 64'(ax_ready), 64'd1);
    check("rst_valid", 64'(req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", req_addr, 64'd0);
    check("rst_flags", {61'd0, req_last, req_hit, req_err}, 64'd0);
    rst = 1'b0;
    region_base[0] = 64'h8000_0000; region_len[0] = 64'h4000_0000; region_tag_base[0] = 64'hC000_0000;
    region_base[1] = 64'h0;         region_len[1] = 64'h0;         region_tag_base[1] = 64'h0;
    @(negedge clk);

    run_ax(64'h8000_0000, 8'd7, 3'd3, 2'b01, 4'd1, 100);
    run_ax(64'h8000_03C0, 8'd15, 3'd3, 2'b01, 4'd2, 100);
    run_ax(64'h8000_0030, 8'd3, 3'd3, 2'b10, 4'd3, 100);
    run_ax(64'h0000_1000, 8'd3, 3'd3, 2'b01, 4'd4, 100);
    run_ax(64'hBFFF_FFF0, 8'd3, 3'd3, 2'b01, 4'd5, 100);

    // Backpressure on the first beat, then reset before the second beat.
    model(64'h8000_03C0, 8'd15, 3'd3, 2'b01);
    req_ready = 1'b0;
    send_ax(64'h8000_03C0, 8'd15, 3'd3, 2'b01, 4'd6, ok);
    ex = expq.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(req_valid), 64'd1);
      check("bp_ax_ready", 64'(ax_ready), 64'd0);
      check_beat(ex, 4'd6);
      @(negedge clk);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    ex = expq.pop_front();
    check("bp_second_valid", 64'(req_valid), 64'd1);
    check_beat(ex, 4'd6);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(req_valid), 64'd0);
    check("midrst_ax_ready", 64'(ax_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_fields", {req_addr[57:0], req_last, req_hit, req_err, req_id[2:0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_valid", 64'(req_valid), 64'd0);
    run_ax(64'h8000_03C0, 8'd15, 3'd3, 2'b01, 4'd7, 100);

    // Overlapping regions: lowest index must win.
    region_base[1] = 64'h8000_0000; region_len[1] = 64'h4000_0000; region_tag_base[1] = 64'hD000_0000;
    run_ax(64'h8000_0100, 8'd3, 3'd3, 2'b01, 4'd8, 100);

    for (int it = 0; it < 60; it++) begin
      if (it % 2 == 0) begin
        region_base[1] = 64'h1_0000_0000; region_len[1] = 64'h1000_0000; region_tag_base[1] = 64'h2_0000_0000;
      end else begin
        region_base[1] = 64'hFFFF_FFFF_F000_0000; region_len[1] = 64'h1000_0000;
        region_tag_base[1] = 64'h3_0000_0000;
      end
      case ($urandom_range(0, 4))
        0: a = 64'h8000_0000 + 64'($urandom_range(0, 32'h3FFF_FFFF));
        1: a = 64'hC000_0000 - 64'($urandom_range(0, 32'h8000));
        2: a = region_base[1] + 64'($urandom_range(0, 32'h0FFF_FFFF));
        3: a = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 32'h8000));
        default: a = {$urandom, $urandom};
      endcase
      run_ax(a, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), 70);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
